button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Multi-channel push-button debouncer sampling on the 200 Hz single-cycle tick from the clock divider in pulse mode.
- Sits between the board push-buttons and the game FSM; outputs a clean level and a one-clk_in-cycle press pulse per button.
- Handles metastability (2-flop synchronizer) and contact bounce (per-channel FSM with stability counter).

Parameters:
- NUM_BUTTONS, 5, number of independent button channels (1..16).
- STABLE_TICKS, 4, consecutive agreeing sample ticks required to accept a change (4 ticks at 200 Hz = 20 ms); legal range 1..255.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst  input  1  asynchronous, active-high reset.
- sample_tick  input  1  one-clk_in-cycle-wide enable pulse from the clock divider (PULSE_MODE=1).
- btn_raw  input  NUM_BUTTONS  asynchronous raw button inputs, active-high.
- btn_level  output  NUM_BUTTONS  debounced button level.
- btn_pressed  output  NUM_BUTTONS  one-clk_in-cycle pulse on accepted 0->1 transition.
- btn_released  output  NUM_BUTTONS  present only with DEBOUNCE_RELEASE_PULSE_EN; one-cycle pulse on accepted 1->0.

Behaviour:
- Reset (async, rst=1): synchronizer flops, counters, btn_level, btn_pressed, btn_released all 0; every FSM in IDLE. Reset mid-bounce discards partial counts.
- Synchronizer: two flops per channel, clocked every clk_in cycle, independent of sample_tick. sync = second flop.
- Per-channel FSM, advances only on cycles with sample_tick=1; counter cnt width $clog2(STABLE_TICKS+1):
  - IDLE (level 0): sync=1 -> cnt=1; if STABLE_TICKS==1 go HELD and pulse, else go ARM_PRESS. sync=0 -> stay, cnt=0.
  - ARM_PRESS: sync=1 -> cnt+1; when cnt+1==STABLE_TICKS -> HELD, cnt=0, assert press. sync=0 -> IDLE, cnt=0 (bounce rejected, no pulse).
  - HELD (level 1): sync=0 -> cnt=1; STABLE_TICKS==1 -> IDLE directly, else ARM_RELEASE. sync=1 -> stay.
  - ARM_RELEASE: sync=0 -> cnt+1; at STABLE_TICKS -> IDLE, cnt=0 (release pulse if enabled). sync=1 -> HELD, cnt=0.
- btn_level = 1 in HELD and ARM_RELEASE, 0 in IDLE and ARM_PRESS; registered.
- btn_pressed registered: high for exactly the clk_in cycle following the sample_tick cycle that entered HELD; never high two consecutive cycles.
- Latency: raw edge -> 2 clk_in synchronizer -> STABLE_TICKS consecutive agreeing ticks -> +1 clk_in to output.
- Without sample_tick, FSMs and counters hold; btn_level holds.
- sample_tick held high continuously: FSM advances every clk_in cycle (legal, used in sim).
- Channels fully independent; simultaneous presses on several channels pulse in the same cycle.
- Counter never exceeds STABLE_TICKS; no wrap-around.

Optional Feature:
- Macro DEBOUNCE_RELEASE_PULSE_EN.
- Defined: btn_released port exists; pulses one cycle after the tick that moves ARM_RELEASE -> IDLE (or HELD -> IDLE when STABLE_TICKS==1). Reset value 0.
- Undefined: port and its register absent; FSM transitions unchanged.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, ARM_PRESS=2'd1, HELD=2'd2, ARM_RELEASE=2'd3) and default debounce constants (200 Hz tick, 20 ms window).
- Sub-module debounce_channel: single-bit synchronizer + FSM + counter; top generates NUM_BUTTONS instances.

Test Plan:
- Reset: assert rst with btn_raw=5'b11111, sample_tick toggling -> all outputs 0 throughout; release rst -> btn_level=1 after 2 clk + 4 ticks + 1 clk.
- Clean press ch0: btn_raw[0]=1 held, STABLE_TICKS=4 -> btn_pressed[0] high exactly 1 cycle after 4th tick; btn_level[0]=1 from same cycle.
- Bounce: btn_raw[1] toggles 1,0,1 across ticks 1-3, then stable 1 -> single btn_pressed[1] pulse only after 4 consecutive 1 samples.
- Glitch between ticks: btn_raw[2] high for 10 clk_in with no tick -> no state change, no pulse.
- Simultaneous: btn_raw=5'b10101 at once -> btn_pressed=5'b10101 in one cycle; release with DEBOUNCE_RELEASE_PULSE_EN -> btn_released=5'b10101 after 4 ticks.
- STABLE_TICKS=1, async rst mid-ARM_PRESS -> counters cleared, no pulse; press after reset -> pulse after first tick.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// button_debouncer_pkg: shared types and constants for the push-button debouncer.
// Provides the per-channel FSM state encoding, default debounce constants
// (200 Hz sample tick, 20 ms acceptance window) and a counter-width helper.
// Optional feature macro used by the other files: DEBOUNCE_RELEASE_PULSE_EN.
package button_debouncer_pkg;

    // Per-channel debounce FSM states
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ARM_PRESS   = 2'd1,
        ST_HELD        = 2'd2,
        ST_ARM_RELEASE = 2'd3
    } db_state_e;

    // Default sampling rate and acceptance window
    localparam int DEFAULT_TICK_HZ   = 200;
    localparam int DEFAULT_WINDOW_MS = 20;

    // 20 ms at 200 Hz -> 4 consecutive agreeing samples
    localparam int DEFAULT_STABLE_TICKS =
        (DEFAULT_WINDOW_MS * DEFAULT_TICK_HZ) / 1000;

    localparam int DEFAULT_NUM_BUTTONS = 5;

    // Width of a counter that must hold values 0..n
    function automatic int cnt_width(input int n);
        if (n < 1) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// button_debouncer_if: handshake-free bundle between board buttons and the game FSM.
// Signals: sample_tick (tick enable), btn_raw (raw buttons), btn_level,
// btn_pressed and, with DEBOUNCE_RELEASE_PULSE_EN, btn_released.
// master = stimulus/consumer side, slave = the debouncer.
interface button_debouncer_if
    import button_debouncer_pkg::*;
#(
    parameter int NUM_BUTTONS = DEFAULT_NUM_BUTTONS
);

    logic                   sample_tick;
    logic [NUM_BUTTONS-1:0] btn_raw;
    logic [NUM_BUTTONS-1:0] btn_level;
    logic [NUM_BUTTONS-1:0] btn_pressed;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    logic [NUM_BUTTONS-1:0] btn_released;
`endif

`ifdef DEBOUNCE_RELEASE_PULSE_EN
    modport master (
        output sample_tick,
        output btn_raw,
        input  btn_level,
        input  btn_pressed,
        input  btn_released
    );

    modport slave (
        input  sample_tick,
        input  btn_raw,
        output btn_level,
        output btn_pressed,
        output btn_released
    );
`else
    modport master (
        output sample_tick,
        output btn_raw,
        input  btn_level,
        input  btn_pressed
    );

    modport slave (
        input  sample_tick,
        input  btn_raw,
        output btn_level,
        output btn_pressed
    );
`endif

endinterface

// File: rtl/button_debouncer_channel.sv
// debounce_channel: one button: 2-flop synchronizer + debounce FSM + stability counter.
// Ports: clk_in, rst (async, active-high), i_tick (sample enable), i_raw (raw button),
// o_level (debounced level), o_pressed (1-cycle press pulse),
// o_released (1-cycle release pulse, only with DEBOUNCE_RELEASE_PULSE_EN).
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
)(
    input  logic clk_in,
    input  logic rst,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_level,
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    output logic o_released,
`endif
    output logic o_pressed
);

    localparam int CW = cnt_width(STABLE_TICKS);

    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    // A one-tick window skips both ARM states
    localparam bit SINGLE = (STABLE_TICKS == 1);

    logic          r_meta;
    logic          r_sync;
    db_state_e     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_pressed;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    logic          r_released;
`endif

    logic [CW-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + ONE;

    // Synchronizer runs every clock, independent of the tick
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    // Debounce FSM; advances only on tick cycles, pulses last one clock
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_level    <= 1'b0;
            r_pressed  <= 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
            r_released <= 1'b0;
`endif
        end else begin
            r_pressed  <= 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
            r_released <= 1'b0;
`endif
            if (i_tick) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (r_sync) begin
                            if (SINGLE) begin
                                r_state   <= ST_HELD;
                                r_cnt     <= '0;
                                r_level   <= 1'b1;
                                r_pressed <= 1'b1;
                            end else begin
                                r_state <= ST_ARM_PRESS;
                                r_cnt   <= ONE;
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    ST_ARM_PRESS: begin
                        if (r_sync) begin
                            if (w_cnt_inc == LAST) begin
                                r_state   <= ST_HELD;
                                r_cnt     <= '0;
                                r_level   <= 1'b1;
                                r_pressed <= 1'b1;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            // Bounce: drop partial count
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    ST_HELD: begin
                        if (!r_sync) begin
                            if (SINGLE) begin
                                r_state    <= ST_IDLE;
                                r_cnt      <= '0;
                                r_level    <= 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
                                r_released <= 1'b1;
`endif
                            end else begin
                                r_state <= ST_ARM_RELEASE;
                                r_cnt   <= ONE;
                            end
                        end
                    end
                    ST_ARM_RELEASE: begin
                        if (!r_sync) begin
                            if (w_cnt_inc == LAST) begin
                                r_state    <= ST_IDLE;
                                r_cnt      <= '0;
                                r_level    <= 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
                                r_released <= 1'b1;
`endif
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_state <= ST_HELD;
                            r_cnt   <= '0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_level    = r_level;
    assign o_pressed  = r_pressed;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    assign o_released = r_released;
`endif

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: multi-channel push-button debouncer driven by a 200 Hz tick.
// Ports: clk_in, rst (async, active-high), bus (slave modport: sample_tick,
// btn_raw in; btn_level, btn_pressed and, with DEBOUNCE_RELEASE_PULSE_EN, btn_released out).
// Each channel is an independent debounce_channel instance.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int NUM_BUTTONS  = DEFAULT_NUM_BUTTONS,
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
)(
    input  logic                clk_in,
    input  logic                rst,
    button_debouncer_if.slave   bus
);

    logic [NUM_BUTTONS-1:0] w_level;
    logic [NUM_BUTTONS-1:0] w_pressed;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    logic [NUM_BUTTONS-1:0] w_released;
`endif

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_ch (
            .clk_in     (clk_in),
            .rst        (rst),
            .i_tick     (bus.sample_tick),
            .i_raw      (bus.btn_raw[g]),
            .o_level    (w_level[g]),
`ifdef DEBOUNCE_RELEASE_PULSE_EN
            .o_released (w_released[g]),
`endif
            .o_pressed  (w_pressed[g])
        );
    end

    assign bus.btn_level    = w_level;
    assign bus.btn_pressed  = w_pressed;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    assign bus.btn_released = w_released;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed + random bench for button_debouncer.
// Two instances (STABLE_TICKS=4 and 1) share stimulus and are checked against a run-length model.
module tb_button_debouncer;

    localparam int NB = 5;

    logic          clk_in = 1'b0;
    logic          rst    = 1'b1;
    logic          tick   = 1'b0;
    logic [NB-1:0] raw    = '0;

    always #5 clk_in = ~clk_in;

    button_debouncer_if #(.NUM_BUTTONS(NB)) bus0 ();
    button_debouncer_if #(.NUM_BUTTONS(NB)) bus1 ();

    assign bus0.sample_tick = tick;
    assign bus0.btn_raw     = raw;
    assign bus1.sample_tick = tick;
    assign bus1.btn_raw     = raw;

    button_debouncer #(.NUM_BUTTONS(NB), .STABLE_TICKS(4)) dut0 (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus0)
    );

    button_debouncer #(.NUM_BUTTONS(NB), .STABLE_TICKS(1)) dut1 (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: raw delayed two clocks, then per-channel run length
    // of ticks disagreeing with the accepted level.
    int            stk [2] = '{4, 1};
    logic [NB-1:0] d1, d2;
    logic [NB-1:0] m_level [2];
    logic [NB-1:0] m_press [2];
    logic [NB-1:0] m_rel   [2];
    int            run [2][NB];

    int            np0 [NB];
    int            ncyc, pcyc0, pcyc1;
    logic [NB-1:0] pv0, rv0;

    task automatic chkv(input string tag, input logic [NB-1:0] obs,
                        input logic [NB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        d1 = '0;
        d2 = '0;
        for (int k = 0; k < 2; k++) begin
            m_level[k] = '0;
            m_press[k] = '0;
            m_rel[k]   = '0;
            for (int c = 0; c < NB; c++) run[k][c] = 0;
        end
    endtask

    task automatic model_edge();
        logic [NB-1:0] sy;
        if (rst) begin
            model_reset();
            return;
        end
        sy = d2;
        d2 = d1;
        d1 = raw;
        for (int k = 0; k < 2; k++) begin
            m_press[k] = '0;
            m_rel[k]   = '0;
            if (tick) begin
                for (int c = 0; c < NB; c++) begin
                    if (sy[c] != m_level[k][c]) begin
                        run[k][c]++;
                        if (run[k][c] >= stk[k]) begin
                            if (m_level[k][c]) m_rel[k][c] = 1'b1;
                            else m_press[k][c] = 1'b1;
                            m_level[k][c] = ~m_level[k][c];
                            run[k][c] = 0;
                        end
                    end else begin
                        run[k][c] = 0;
                    end
                end
            end
        end
    endtask

    task automatic clear_stats();
        ncyc  = 0;
        pcyc0 = -1;
        pcyc1 = -1;
        pv0   = '0;
        rv0   = '0;
        for (int c = 0; c < NB; c++) np0[c] = 0;
    endtask

    task automatic cyc(input logic [NB-1:0] r, input logic t, input logic rs);
        @(negedge clk_in);
        raw  = r;
        tick = t;
        rst  = rs;
        if (rs) model_reset();
        @(posedge clk_in);
        model_edge();
        #1;
        chkv("level_st4", bus0.btn_level, m_level[0]);
        chkv("press_st4", bus0.btn_pressed, m_press[0]);
        chkv("level_st1", bus1.btn_level, m_level[1]);
        chkv("press_st1", bus1.btn_pressed, m_press[1]);
`ifdef DEBOUNCE_RELEASE_PULSE_EN
        chkv("rel_st4", bus0.btn_released, m_rel[0]);
        chkv("rel_st1", bus1.btn_released, m_rel[1]);
        if (bus0.btn_released != '0) rv0 = bus0.btn_released;
`endif
        for (int c = 0; c < NB; c++) begin
            if (bus0.btn_pressed[c]) np0[c]++;
        end
        if (bus0.btn_pressed != '0) begin
            pv0   = bus0.btn_pressed;
            pcyc0 = ncyc;
        end
        if (bus1.btn_pressed != '0) pcyc1 = ncyc;
        ncyc++;
    endtask

    initial begin
        int            first0, first1;
        logic [NB-1:0] rr;
        logic [9:0]    bseq;
        logic          t;

        model_reset();
        clear_stats();

        // Reset held with buttons down and tick toggling
        for (int i = 0; i < 10; i++) cyc('1, 1'(i % 2), 1'b1);
        chkv("rst_level", bus0.btn_level, '0);
        chkv("rst_press", bus0.btn_pressed, '0);

        // Release reset: 2 sync clocks + N ticks
        clear_stats();
        first0 = -1;
        first1 = -1;
        for (int n = 0; n < 20; n++) begin
            cyc('1, 1'b1, 1'b0);
            if (first0 < 0 && bus0.btn_level == 5'h1f) first0 = n;
            if (first1 < 0 && bus1.btn_level == 5'h1f) first1 = n;
        end
        chki("lat_level_st4", first0, 5);
        chki("lat_level_st1", first1, 2);
        chki("lat_press_st4", pcyc0, 5);
        for (int i = 0; i < 20; i++) cyc('0, 1'b1, 1'b0);

        // Clean press on ch0, tick every 4th clock
        clear_stats();
        for (int i = 0; i < 40; i++) cyc(5'b00001, 1'(i % 4 == 3), 1'b0);
        chki("clean_cyc_st4", pcyc0, 15);
        chki("clean_cnt_st4", np0[0], 1);
        chkv("clean_vec_st4", pv0, 5'b00001);
        chki("clean_cyc_st1", pcyc1, 3);
        for (int i = 0; i < 40; i++) cyc('0, 1'(i % 4 == 3), 1'b0);

        // Bounce on ch1: per-tick samples 1,0,1,1,1,...
        bseq = 10'b1111111101;
        clear_stats();
        for (int i = 0; i < 40; i++)
            cyc({3'b000, bseq[i / 4], 1'b0}, 1'(i % 4 == 3), 1'b0);
        chki("bounce_cyc_st4", pcyc0, 23);
        chki("bounce_cnt_st4", np0[1], 1);
        chki("bounce_cyc_st1", pcyc1, 11);
        for (int i = 0; i < 40; i++) cyc('0, 1'(i % 4 == 3), 1'b0);

        // Glitch on ch2 with no tick
        clear_stats();
        for (int i = 0; i < 10; i++) cyc(5'b00100, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc('0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cyc('0, 1'(i % 4 == 3), 1'b0);
        chki("glitch_cnt_st4", np0[2], 0);
        chki("glitch_cyc_st1", pcyc1, -1);
        chkv("glitch_level", bus0.btn_level, '0);

        // Simultaneous press and release
        clear_stats();
        for (int i = 0; i < 24; i++) cyc(5'b10101, 1'(i % 4 == 3), 1'b0);
        chkv("simul_press", pv0, 5'b10101);
        chki("simul_cyc", pcyc0, 15);
        clear_stats();
        for (int i = 0; i < 24; i++) cyc('0, 1'(i % 4 == 3), 1'b0);
`ifdef DEBOUNCE_RELEASE_PULSE_EN
        chkv("simul_release", rv0, 5'b10101);
`endif
        chkv("simul_level_off", bus0.btn_level, '0);

        // Async reset while ch3 is mid-count
        clear_stats();
        for (int i = 0; i < 8; i++) cyc(5'b01000, 1'(i % 4 == 3), 1'b0);
        chkv("arm_level", bus0.btn_level, '0);
        @(negedge clk_in);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chkv("async_level_st4", bus0.btn_level, '0);
        chkv("async_level_st1", bus1.btn_level, '0);
        for (int i = 0; i < 3; i++) cyc(5'b01000, 1'b1, 1'b1);
        clear_stats();
        for (int i = 0; i < 20; i++) cyc(5'b01000, 1'(i % 4 == 3), 1'b0);
        chki("post_rst_cyc_st4", pcyc0, 15);
        chki("post_rst_cnt_st4", np0[3], 1);
        chki("post_rst_cyc_st1", pcyc1, 3);
        for (int i = 0; i < 20; i++) cyc('0, 1'b1, 1'b0);

        // Random bounce, random ticks, occasional resets
        rr = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
            end
            t = (i >= 600 && i < 900) ? 1'b1 : ($urandom_range(0, 2) == 0);
            cyc(rr, t, ($urandom_range(0, 399) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
